branch_history_table: RTL and testbench
=======================================

BRANCH_HISTORY_TABLE -- requirements
Module: branch_history_table

Interface
REQ-001 Parameter IDX_BITS, default 4, table index width; DEPTH = 2**IDX_BITS entries.
REQ-002 Parameter CNT_BITS, default 2, saturating-counter width per entry; legal range 1..4.
REQ-003 Parameter INIT_STATE, default all-ones (strongly taken), value every entry takes on reset and Preset sweep.
REQ-004 CLK  in  1  sole clock; all state changes on its rising edge.
REQ-005 Reset_n  in  1  asynchronous, active-low reset.
REQ-006 Preset  in  1  synchronous request to re-initialise the whole table.
REQ-007 IF_Index  in  IDX_BITS  fetch-stage lookup index (PC bits).
REQ-008 Hit  in  1  BTB hit for the fetch-stage lookup.
REQ-009 EX_Hit  in  1  update valid: resolved branch in EX.
REQ-010 EX_Index  in  IDX_BITS  index of the resolved branch.
REQ-011 Success  in  1  resolved outcome, 1 = taken.
REQ-012 EX_Predicted  in  1  prediction originally issued for the resolved branch.
REQ-013 JumpPredict  out  1  registered prediction for the previous cycle's lookup.
REQ-014 Busy  out  1  high while the Preset sweep runs.
REQ-015 Mispredict_Count  out  16  saturating count of resolved mispredictions.

Function
REQ-016 Lookup latency: exactly 1 cycle; JumpPredict(t+1) = Hit(t) AND MSB of entry[IF_Index(t)].
REQ-017 Update on EX_Hit=1 while IDLE: entry[EX_Index] increments if Success=1, decrements if Success=0, saturating at 0 and 2**CNT_BITS-1.
REQ-018 Same-cycle collision (EX_Hit=1, EX_Index == IF_Index): lookup uses the post-update value (write-first forwarding).
REQ-019 FSM states IDLE, SWEEP; IDLE->SWEEP on Preset=1; SWEEP->IDLE after writing entry DEPTH-1.
REQ-020 SWEEP writes INIT_STATE to entry k, k = 0..DEPTH-1, one entry per cycle; sweep lasts DEPTH cycles.
REQ-021 Preset=1 during SWEEP restarts k at 0.
REQ-022 During SWEEP: Busy=1, EX_Hit updates dropped, Mispredict_Count frozen, JumpPredict registers 0.
REQ-023 Mispredict_Count increments by 1 when EX_Hit=1, state IDLE, and EX_Predicted != Success; holds at 16'hFFFF.
REQ-024 Index arithmetic: sweep pointer IDX_BITS wide, no wrap past DEPTH-1 (exit instead).
REQ-025 CNT_BITS=1 degenerates to last-outcome predictor; same rules apply.

Reset
REQ-026 Reset_n=0 asynchronously: all entries = INIT_STATE, state IDLE, sweep pointer 0, JumpPredict 0, Busy 0, Mispredict_Count 0.
REQ-027 Reset_n asserted mid-sweep aborts the sweep; table already fully INIT_STATE on release, no sweep resumes.
REQ-028 First update/lookup accepted on the first rising edge after Reset_n deasserts.

Structure
REQ-029 Shared package bp_pkg holds the state enum (IDLE, SWEEP), default IDX_BITS/CNT_BITS, and the mispredict-counter width constant 16.
REQ-030 One sub-module sat_counter_next: combinational CNT_BITS-wide saturating inc/dec, used for the update path and forwarding.
REQ-031 Table is a flop array (no RAM macro) to permit async reset and same-cycle forwarding.

Verification
REQ-032 Reset release, lookup IF_Index=5, Hit=1 -> next cycle JumpPredict=1 (INIT_STATE=3).
REQ-033 Three updates index 5 Success=0, then lookup 5 Hit=1 -> entry 0, JumpPredict=0; fourth Success=0 keeps entry 0.
REQ-034 Entry 2 at 1, EX_Hit=1 EX_Index=2 Success=1 and IF_Index=2 Hit=1 same cycle -> JumpPredict=1 next cycle.
REQ-035 Preset pulse -> Busy=1 for 16 cycles, EX_Hit ignored, then all entries read 3; Preset again at sweep cycle 8 -> Busy lasts 8+16 cycles total.
REQ-036 65540 EX_Hit with EX_Predicted=1 Success=0 -> Mispredict_Count=16'hFFFF; matching pairs leave count unchanged.
REQ-037 Reset_n low at sweep cycle 5 -> Busy=0 immediately, state IDLE, all outputs at reset values.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared definitions for the branch history table.
// Contents: the controller state encoding, the default table geometry and
// the width of the misprediction counter.
package bp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } bht_state_t;

  localparam int unsigned BHT_IDX_BITS     = 4;
  localparam int unsigned BHT_CNT_BITS     = 2;
  localparam int unsigned MISPRED_CNT_BITS = 16;

endpackage

// File: rtl/branch_history_table_if.sv
// Fetch/execute-side signal bundle of the branch history table.
// master: predictor user (drives Preset, lookup and update fields,
//         receives JumpPredict, Busy, Mispredict_Count).
// slave : the branch_history_table itself.
interface branch_history_table_if
  import bp_pkg::*;
#(
  parameter int unsigned IDX_BITS = BHT_IDX_BITS
);

  logic                        Preset;
  logic [IDX_BITS-1:0]         IF_Index;
  logic                        Hit;
  logic                        EX_Hit;
  logic [IDX_BITS-1:0]         EX_Index;
  logic                        Success;
  logic                        EX_Predicted;
  logic                        JumpPredict;
  logic                        Busy;
  logic [MISPRED_CNT_BITS-1:0] Mispredict_Count;

  modport master (
    output Preset, IF_Index, Hit, EX_Hit, EX_Index, Success, EX_Predicted,
    input  JumpPredict, Busy, Mispredict_Count
  );

  modport slave (
    input  Preset, IF_Index, Hit, EX_Hit, EX_Index, Success, EX_Predicted,
    output JumpPredict, Busy, Mispredict_Count
  );

endinterface

// File: rtl/sat_counter_next.sv
// Combinational next value of a CNT_BITS-wide saturating counter.
// Ports: cnt_in  - current value
//        inc     - 1 = count up, 0 = count down
//        cnt_out - next value, clamped to 0 .. 2**CNT_BITS-1
module sat_counter_next #(
  parameter int unsigned CNT_BITS = 2
) (
  input  logic [CNT_BITS-1:0] cnt_in,
  input  logic                inc,
  output logic [CNT_BITS-1:0] cnt_out
);

  localparam logic [CNT_BITS-1:0] ONE = CNT_BITS'(1);

  always_comb begin
    cnt_out = cnt_in;
    if (inc) begin
      if (cnt_in != '1) cnt_out = cnt_in + ONE;
    end else begin
      if (cnt_in != '0) cnt_out = cnt_in - ONE;
    end
  end

endmodule

// File: rtl/branch_history_table.sv
// Branch history table: DEPTH saturating counters indexed by PC bits.
// Ports: CLK     - clock, all state changes on the rising edge
//        Reset_n - asynchronous active-low reset
//        bus     - slave side of branch_history_table_if: Preset sweep
//                  request, fetch lookup (IF_Index/Hit), execute update
//                  (EX_Hit/EX_Index/Success/EX_Predicted), registered
//                  JumpPredict, Busy during sweep, Mispredict_Count.
module branch_history_table
  import bp_pkg::*;
#(
  parameter int unsigned          IDX_BITS   = BHT_IDX_BITS,
  parameter int unsigned          CNT_BITS   = BHT_CNT_BITS,
  parameter logic [CNT_BITS-1:0]  INIT_STATE = '1
) (
  input  logic                   CLK,
  input  logic                   Reset_n,
  branch_history_table_if.slave  bus
);

  localparam int unsigned                  DEPTH       = 2 ** IDX_BITS;
  localparam logic [IDX_BITS-1:0]          LAST_IDX    = '1;
  localparam logic [IDX_BITS-1:0]          IDX_ONE     = IDX_BITS'(1);
  localparam logic [MISPRED_CNT_BITS-1:0]  MISPRED_MAX = '1;
  localparam logic [MISPRED_CNT_BITS-1:0]  MISPRED_ONE = MISPRED_CNT_BITS'(1);

  bht_state_t                  state_q, state_d;
  logic [IDX_BITS-1:0]         ptr_q, ptr_d;
  logic [CNT_BITS-1:0]         cnt_q [DEPTH];

  logic                        upd_en;
  logic [CNT_BITS-1:0]         upd_cur;
  logic [CNT_BITS-1:0]         upd_next;
  logic [CNT_BITS-1:0]         look_val;

  logic                        wr_en;
  logic [IDX_BITS-1:0]         wr_idx;
  logic [CNT_BITS-1:0]         wr_val;

  logic                        jp_q;
  logic [MISPRED_CNT_BITS-1:0] mis_q;

  // Resolved-branch updates are only honoured outside the sweep.
  assign upd_en  = bus.EX_Hit && (state_q == IDLE);
  assign upd_cur = cnt_q[bus.EX_Index];

  sat_counter_next #(
    .CNT_BITS (CNT_BITS)
  ) u_next (
    .cnt_in  (upd_cur),
    .inc     (bus.Success),
    .cnt_out (upd_next)
  );

  // Write-first: a lookup hitting the entry being updated this cycle sees
  // the updated counter rather than the stale table contents.
  always_comb begin
    look_val = cnt_q[bus.IF_Index];
    if (upd_en && (bus.EX_Index == bus.IF_Index)) look_val = upd_next;
  end

  // Next-state and table write port selection.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wr_en   = 1'b0;
    wr_idx  = bus.EX_Index;
    wr_val  = upd_next;
    case (state_q)
      IDLE: begin
        wr_en = bus.EX_Hit;
        if (bus.Preset) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        wr_en  = 1'b1;
        wr_idx = ptr_q;
        wr_val = INIT_STATE;
        if (bus.Preset) begin
          ptr_d = '0;
        end else if (ptr_q == LAST_IDX) begin
          // Exit instead of letting the pointer wrap back to entry 0.
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + IDX_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Flop array rather than RAM so the whole table can be reset at once.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '{default: INIT_STATE};
    end else if (wr_en) begin
      cnt_q[wr_idx] <= wr_val;
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      jp_q  <= 1'b0;
      mis_q <= '0;
    end else begin
      jp_q <= (state_q == IDLE) && bus.Hit && look_val[CNT_BITS-1];
      if (upd_en && (bus.EX_Predicted != bus.Success) && (mis_q != MISPRED_MAX))
        mis_q <= mis_q + MISPRED_ONE;
    end
  end

  assign bus.JumpPredict      = jp_q;
  assign bus.Busy             = (state_q == SWEEP);
  assign bus.Mispredict_Count = mis_q;

endmodule

// File: tb/tb_branch_history_table.sv
module tb_branch_history_table;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  branch_history_table_if #(.IDX_BITS(4)) bus ();

  branch_history_table #(
    .IDX_BITS   (4),
    .CNT_BITS   (2),
    .INIT_STATE (2'b11)
  ) dut (
    .CLK     (clk),
    .Reset_n (rst_n),
    .bus     (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ex(input logic hit, input logic [3:0] idx, input logic succ, input logic pred);
    bus.EX_Hit       = hit;
    bus.EX_Index     = idx;
    bus.Success      = succ;
    bus.EX_Predicted = pred;
  endtask

  task automatic set_if(input logic hit, input logic [3:0] idx);
    bus.Hit      = hit;
    bus.IF_Index = idx;
  endtask

  initial begin
    int busy_cnt;
    int jp_bad;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.Preset = 1'b0;
    set_if(1'b0, 4'd0);
    set_ex(1'b0, 4'd0, 1'b0, 1'b0);

    // Reset state
    #1;
    check("reset_jp",   32'(bus.JumpPredict), 32'd0);
    check("reset_busy", 32'(bus.Busy), 32'd0);
    check("reset_mis",  32'(bus.Mispredict_Count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First lookup after release, INIT_STATE=3
    set_if(1'b1, 4'd5);
    tick();
    check("first_lookup", 32'(bus.JumpPredict), 32'd1);
    set_if(1'b0, 4'd5);
    tick();
    check("no_hit", 32'(bus.JumpPredict), 32'd0);

    // Entry 5 down to 0 and saturation at 0
    set_ex(1'b1, 4'd5, 1'b0, 1'b0);
    tick(); tick(); tick();
    set_ex(1'b0, 4'd5, 1'b0, 1'b0);
    set_if(1'b1, 4'd5);
    tick();
    check("e5_zero", 32'(bus.JumpPredict), 32'd0);
    set_if(1'b0, 4'd5);
    set_ex(1'b1, 4'd5, 1'b0, 1'b0);
    tick();
    set_ex(1'b1, 4'd5, 1'b1, 1'b1);
    tick();
    set_ex(1'b0, 4'd5, 1'b0, 1'b0);
    set_if(1'b1, 4'd5);
    tick();
    check("e5_sat0_then1", 32'(bus.JumpPredict), 32'd0);
    set_if(1'b0, 4'd5);
    set_ex(1'b1, 4'd5, 1'b1, 1'b1);
    tick();
    set_ex(1'b0, 4'd5, 1'b0, 1'b0);
    set_if(1'b1, 4'd5);
    tick();
    check("e5_two", 32'(bus.JumpPredict), 32'd1);
    set_if(1'b0, 4'd0);

    // Entry 2 to 1, then same-cycle collisions
    set_ex(1'b1, 4'd2, 1'b0, 1'b0);
    tick(); tick();
    set_ex(1'b0, 4'd2, 1'b0, 1'b0);
    set_if(1'b1, 4'd2);
    tick();
    check("e2_one", 32'(bus.JumpPredict), 32'd0);
    set_ex(1'b1, 4'd2, 1'b1, 1'b1);
    tick();
    check("fwd_inc", 32'(bus.JumpPredict), 32'd1);
    set_ex(1'b1, 4'd2, 1'b0, 1'b0);
    tick();
    check("fwd_dec", 32'(bus.JumpPredict), 32'd0);
    set_ex(1'b1, 4'd3, 1'b0, 1'b0);
    set_if(1'b1, 4'd4);
    tick();
    check("no_collision", 32'(bus.JumpPredict), 32'd1);
    set_if(1'b0, 4'd0);

    // Misprediction counting
    check("mis_zero", 32'(bus.Mispredict_Count), 32'd0);
    set_ex(1'b1, 4'd9, 1'b0, 1'b1);
    tick(); tick(); tick();
    check("mis_three", 32'(bus.Mispredict_Count), 32'd3);
    set_ex(1'b1, 4'd9, 1'b1, 1'b1);
    tick();
    set_ex(1'b1, 4'd9, 1'b0, 1'b0);
    tick();
    check("mis_match", 32'(bus.Mispredict_Count), 32'd3);
    set_ex(1'b0, 4'd9, 1'b0, 1'b1);
    tick();
    check("mis_no_exhit", 32'(bus.Mispredict_Count), 32'd3);

    // Preset sweep: 16 busy cycles, updates dropped, prediction forced 0
    bus.Preset = 1'b1;
    tick();
    bus.Preset = 1'b0;
    set_ex(1'b1, 4'd0, 1'b0, 1'b1);
    set_if(1'b1, 4'd0);
    busy_cnt = 0;
    jp_bad   = 0;
    while (bus.Busy && busy_cnt < 40) begin
      busy_cnt++;
      tick();
      if (bus.JumpPredict !== 1'b0) jp_bad++;
    end
    set_ex(1'b0, 4'd0, 1'b0, 1'b0);
    set_if(1'b0, 4'd0);
    check("sweep_len", 32'(busy_cnt), 32'd16);
    check("sweep_jp_zero", 32'(jp_bad), 32'd0);
    check("sweep_mis_frozen", 32'(bus.Mispredict_Count), 32'd3);
    for (int i = 0; i < 16; i++) begin
      set_if(1'b1, 4'(i));
      tick();
      check($sformatf("sweep_entry%0d", i), 32'(bus.JumpPredict), 32'd1);
    end
    set_if(1'b0, 4'd0);
    // Entry 2 was 1 before the sweep; a decrement from 3 still predicts taken
    set_ex(1'b1, 4'd2, 1'b0, 1'b0);
    tick();
    set_ex(1'b0, 4'd2, 1'b0, 1'b0);
    set_if(1'b1, 4'd2);
    tick();
    check("e2_after_sweep", 32'(bus.JumpPredict), 32'd1);
    set_if(1'b0, 4'd0);

    // Preset again during the 8th busy cycle restarts the sweep
    bus.Preset = 1'b1;
    tick();
    busy_cnt = 0;
    while (bus.Busy && busy_cnt < 60) begin
      busy_cnt++;
      bus.Preset = (busy_cnt == 8);
      tick();
    end
    bus.Preset = 1'b0;
    check("restart_len", 32'(busy_cnt), 32'd24);

    // Reset during a sweep
    set_ex(1'b1, 4'd15, 1'b0, 1'b0);
    tick(); tick();
    set_ex(1'b0, 4'd15, 1'b0, 1'b0);
    bus.Preset = 1'b1;
    tick();
    bus.Preset = 1'b0;
    tick(); tick(); tick(); tick();
    check("pre_abort_busy", 32'(bus.Busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.Busy), 32'd0);
    check("abort_jp",   32'(bus.JumpPredict), 32'd0);
    check("abort_mis",  32'(bus.Mispredict_Count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_if(1'b1, 4'd15);
    tick();
    check("abort_e15_init", 32'(bus.JumpPredict), 32'd1);
    check("abort_no_resume", 32'(bus.Busy), 32'd0);
    set_if(1'b0, 4'd0);

    // Mispredict counter saturation
    set_ex(1'b1, 4'd9, 1'b0, 1'b1);
    for (int i = 0; i < 65540; i++) tick();
    check("mis_sat", 32'(bus.Mispredict_Count), 32'h0000FFFF);
    set_ex(1'b1, 4'd9, 1'b1, 1'b1);
    tick();
    check("mis_sat_match", 32'(bus.Mispredict_Count), 32'h0000FFFF);
    set_ex(1'b0, 4'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
